// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
// Shared definitions for the TX FIFO write-port arbiter:
//   arb_state_e  - write FSM state encoding
//   REQ_RD/ALU   - requester ids used by the round-robin pointer
//   DROP_CNT_W   - width of the optional dropped-request counter
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_RD = 2'd1,
        SEND_B0 = 2'd2,
        SEND_B1 = 2'd3
    } arb_state_e;

    localparam logic REQ_RD  = 1'b0;
    localparam logic REQ_ALU = 1'b1;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/arb_hold_buf.sv
// arb_hold_buf
// One-entry holding buffer in front of the FIFO write arbiter.
// A valid pulse is captured when the buffer is empty or is being released
// on the same edge; otherwise the pulse is dropped and flagged.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   valid, din   - single-cycle request and its payload
//   rel          - arbiter has consumed the entry this edge
//   full         - entry occupied
//   ready        - registered "buffer empty"
//   dout         - held payload
//   drop         - valid pulse lost this cycle (combinational)
module arb_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [W-1:0] din,
    input  logic         rel,
    output logic         full,
    output logic         ready,
    output logic [W-1:0] dout,
    output logic         drop
);

    logic capture;

    always_comb begin
        capture = valid && (!full || rel);
        drop    = valid && full && !rel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            ready <= 1'b1;
            dout  <= '0;
        end else if (capture) begin
            full  <= 1'b1;
            ready <= 1'b0;
            dout  <= din;
        end else if (rel) begin
            full  <= 1'b0;
            ready <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the TX async FIFO write port (REF_CLK domain) between register-file
// read responses (one byte) and ALU results (two bytes, never interleaved).
// Each requester has a one-entry buffer; contention is resolved round-robin.
// Optional feature macro: DROP_CNT_EN adds a saturating dropped-request count.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   rd_data/rd_valid        - register read response in
//   rd_ready                - registered, register-read buffer empty
//   alu_out/alu_valid       - ALU result in (2*DATA_WIDTH)
//   alu_ready               - registered, ALU buffer empty
//   fifo_full               - FIFO full flag, gates writes combinationally
//   wr_data                 - registered byte to the FIFO
//   wr_inc                  - FIFO write strobe
//   drop_cnt                - (DROP_CNT_EN only) dropped valid pulses
//
// state   | meaning
// IDLE    | no transfer; pick next requester
// SEND_RD | register byte on wr_data
// SEND_B0 | first ALU byte on wr_data
// SEND_B1 | second ALU byte on wr_data
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_inc
`ifdef DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

    arb_state_e state, state_next;
    logic       rr_ptr, rr_next;
    logic [DATA_WIDTH-1:0] wr_data_next;

    logic                    rd_full, rd_rel, rd_drop;
    logic [DATA_WIDTH-1:0]   rd_buf;
    logic                    alu_full, alu_rel, alu_drop;
    logic [2*DATA_WIDTH-1:0] alu_buf;
    logic [DATA_WIDTH-1:0]   alu_first, alu_second;

    arb_hold_buf #(.W(DATA_WIDTH)) u_rd_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (rd_valid),
        .din   (rd_data),
        .rel   (rd_rel),
        .full  (rd_full),
        .ready (rd_ready),
        .dout  (rd_buf),
        .drop  (rd_drop)
    );

    arb_hold_buf #(.W(2*DATA_WIDTH)) u_alu_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (alu_valid),
        .din   (alu_out),
        .rel   (alu_rel),
        .full  (alu_full),
        .ready (alu_ready),
        .dout  (alu_buf),
        .drop  (alu_drop)
    );

    always_comb begin
        if (MSB_FIRST != 0) begin
            alu_first  = alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
            alu_second = alu_buf[DATA_WIDTH-1:0];
        end else begin
            alu_first  = alu_buf[DATA_WIDTH-1:0];
            alu_second = alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    assign wr_inc = (state != IDLE) && !fifo_full;

    always_comb begin
        state_next   = state;
        wr_data_next = wr_data;
        rr_next      = rr_ptr;
        rd_rel       = 1'b0;
        alu_rel      = 1'b0;
        case (state)
            IDLE: begin
                // Pointer only moves on real contention, so a lone requester
                // never steals the other side's next turn.
                if (rd_full && alu_full) begin
                    if (rr_ptr == REQ_RD) begin
                        state_next   = SEND_RD;
                        wr_data_next = rd_buf;
                    end else begin
                        state_next   = SEND_B0;
                        wr_data_next = alu_first;
                    end
                    rr_next = (rr_ptr == REQ_RD) ? REQ_ALU : REQ_RD;
                end else if (rd_full) begin
                    state_next   = SEND_RD;
                    wr_data_next = rd_buf;
                end else if (alu_full) begin
                    state_next   = SEND_B0;
                    wr_data_next = alu_first;
                end
            end
            SEND_RD: begin
                if (wr_inc) begin
                    rd_rel     = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND_B0: begin
                if (wr_inc) begin
                    state_next   = SEND_B1;
                    wr_data_next = alu_second;
                end
            end
            SEND_B1: begin
                if (wr_inc) begin
                    alu_rel    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= REQ_RD;
            wr_data <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_next;
            wr_data <= wr_data_next;
        end
    end

`ifdef DROP_CNT_EN
    // One extra bit catches the carry so both saturation cases (+1, +2) clip.
    logic [DROP_CNT_W:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt}
                 + {{DROP_CNT_W{1'b0}}, rd_drop}
                 + {{DROP_CNT_W{1'b0}}, alu_drop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_sum[DROP_CNT_W]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[DROP_CNT_W-1:0];
        end
    end
`else
    logic drop_unused;
    assign drop_unused = rd_drop ^ alu_drop;
`endif

endmodule
